// File: rtl/regfile_pkg.sv
// regfile_pkg: constants and helpers shared by the register file and its
// writeback arbiter.
//   XLEN       default data width
//   REG_ADDR_W register address width
//   NUM_REGS   number of architectural registers
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One-hot register mask for a register address.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
    logic [NUM_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: grant logic for the register-file writeback port.
// Build option: define ARB_RR_EN for round-robin arbitration; without it the
// grant is fixed priority (index 0 highest) and no pointer register exists.
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset (pointer -> NUM_REQ-1)
//   req    per-requester request vector
//   xfer   a transfer completes at the coming edge (advances the pointer)
//   grant  one-hot grant, combinational from req and the pointer
module wb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               xfer,
  output logic [NUM_REQ-1:0] grant
);

`ifdef ARB_RR_EN
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0]    ptr_q;
  logic [IdxW-1:0]    grant_idx;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] pick;

  // Requests above the last grant take precedence; if none, wrap to the
  // lowest requesting index. Equivalent to searching from (ptr+1) mod N.
  always_comb begin
    mask      = '0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (IdxW'(i) > ptr_q);
    end
    req_hi = req & mask;
    pick   = (|req_hi) ? req_hi : req;
    // Descending scan so the lowest set bit of pick is the final winner.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IdxW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IdxW'(NUM_REQ - 1);
    end else if (xfer) begin
      ptr_q <= grant_idx;
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  // Fixed priority is stateless; clock, reset and xfer are not needed.
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, xfer};
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates several writeback requesters onto a single
// registered register-file write port, and keeps a busy scoreboard that
// stalls issue on RAW/WAW hazards.
// Build option: ARB_RR_EN selects round-robin arbitration (see wb_rr_arbiter);
// the default build uses fixed priority, index 0 highest.
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req_valid/req_ready       per-requester handshake
//   req_addr/req_data         packed per-requester destination and data
//   issue_valid/rd/rs1/rs2    issuing instruction from decode
//   stall                     issue blocked by a pending write (combinational)
//   wb_we/wb_addr/wb_data     registered write port, one cycle after transfer
//   busy                      registers with a write pending (bit 0 always 0)
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = regfile_pkg::XLEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [XLEN*NUM_REQ-1:0]       req_data,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic [REG_ADDR_W-1:0]         issue_rs1,
  input  logic [REG_ADDR_W-1:0]         issue_rs2,
  output logic                          stall,
  output logic                          wb_we,
  output logic [REG_ADDR_W-1:0]         wb_addr,
  output logic [XLEN-1:0]               wb_data,
  output logic [NUM_REGS-1:0]           busy
);

  logic [NUM_REQ-1:0]    grant;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [NUM_REGS-1:0]   clr_mask, set_mask;
  logic                  wb_we_q;
  logic [REG_ADDR_W-1:0] wb_addr_q;
  logic [XLEN-1:0]       wb_data_q;

  wb_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req_valid),
    .xfer (xfer),
    .grant(grant)
  );

  // No grant may be visible while reset is asserted.
  assign req_ready = rst ? '0 : grant;
  assign xfer      = |req_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // Stall looks only at the registered scoreboard, so a same-cycle transfer
  // cannot release it early. busy_q[0] is always 0, so x0 never stalls.
  assign stall = issue_valid &
                 (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);

  // Set is applied after clear so a same-edge set wins.
  always_comb begin
    clr_mask  = xfer ? reg_onehot(sel_addr) : '0;
    set_mask  = (issue_valid && !stall) ? reg_onehot(issue_rd) : '0;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      // Writes to x0 are accepted but never reach the register file.
      wb_we_q <= xfer && (sel_addr != '0);
      if (xfer) begin
        wb_addr_q <= sel_addr;
        wb_data_q <= sel_data;
      end
      busy_q <= busy_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// checked against a behavioural model. The driver checks combinational
// outputs and queues the expected write-port/busy state for each edge; a
// monitor pops and compares after every rising edge.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XL   = 32;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [5*NREQ-1:0] req_addr;
  logic [XL*NREQ-1:0] req_data;
  logic              issue_valid;
  logic [4:0]        issue_rd, issue_rs1, issue_rs2;
  logic              stall;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [XL-1:0]     wb_data;
  logic [31:0]       busy;

  regfile_wb_arbiter #(
    .NUM_REQ(NREQ),
    .XLEN   (XL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_rs1  (issue_rs1),
    .issue_rs2  (issue_rs2),
    .stall      (stall),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 0;
  bit   rel_pending = 0;

  // Behavioural model state.
  bit          p_valid[NREQ];
  logic [4:0]  p_addr[NREQ];
  logic [31:0] p_data[NREQ];
  logic [31:0] m_busy;
  int          m_ptr;
  int          last_g;

  // Issue stimulus for the next cycle.
  bit         iv;
  logic [4:0] ird, irs1, irs2;

  // Observations taken in the last cycle (after the inputs settled).
  logic [NREQ-1:0] obs_ready;
  logic            obs_stall, obs_we;
  logic [4:0]      obs_waddr;
  logic [31:0]     obs_wdata, obs_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic post(input int i, input logic [4:0] a, input logic [31:0] d);
    if (!p_valid[i]) begin
      p_valid[i] = 1'b1;
      p_addr[i]  = a;
      p_data[i]  = d;
    end
  endtask

  function automatic bit busy_hit(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r];
  endfunction

  task automatic cycle();
    int   g;
    int   idx;
    bit   exp_stall;
    exp_t e;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    if (rel_pending) begin
      rst = 1'b0;
      mon_en = 1'b1;
      rel_pending = 0;
    end
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = p_valid[i];
      req_addr[5*i +: 5]   = p_addr[i];
      req_data[XL*i +: XL] = p_data[i];
    end
    issue_valid = iv;
    issue_rd    = ird;
    issue_rs1   = irs1;
    issue_rs2   = irs2;
    #1;
    obs_ready = req_ready;
    obs_stall = stall;
    obs_we    = wb_we;
    obs_waddr = wb_addr;
    obs_wdata = wb_data;
    obs_busy  = busy;

    // Which requester should win this cycle.
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_RR_EN
      idx = (m_ptr + 1 + k) % NREQ;
`else
      idx = k;
`endif
      if (g < 0 && p_valid[idx]) g = idx;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", obs_ready, exp_ready);

    exp_stall = iv && (busy_hit(irs1) || busy_hit(irs2) || busy_hit(ird));
    chk("stall", obs_stall, exp_stall);

    e = '0;
    if (g >= 0) begin
      e.we   = (p_addr[g] != 5'd0);
      e.addr = p_addr[g];
      e.data = p_data[g];
      m_busy[p_addr[g]] = 1'b0;
      p_valid[g] = 1'b0;
      m_ptr = g;
    end
    if (iv && !exp_stall && ird != 5'd0) m_busy[ird] = 1'b1;
    m_busy[0] = 1'b0;
    e.busy = m_busy;
    exp_q.push_back(e);
    last_g = g;
  endtask

  // Monitor: one expected entry per edge while enabled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_entry actual=none required=queued at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("wb_we", wb_we, e.we);
          if (e.we) begin
            chk("wb_addr", wb_addr, e.addr);
            chk("wb_data", wb_data, e.data);
          end
          chk("busy", busy, e.busy);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    m_busy = '0;
    m_ptr  = NREQ - 1;
    iv = 0; ird = '0; irs1 = '0; irs2 = '0;
  endtask

  initial begin
    int  exp_seq[4];
    int  n;
    logic [31:0] b0;
`ifdef ARB_RR_EN
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 0;
`else
    exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      p_addr[i] = '0;
      p_data[i] = '0;
    end
    model_reset();
    rst = 1'b1;
    req_valid = '1;
    req_addr = '0;
    req_data = '0;
    issue_valid = 1'b0;
    issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;

    // Reset held with every requester asking.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst_ready", req_ready, 3'b000);
      chk("rst_we", wb_we, 1'b0);
      chk("rst_busy", busy, 32'd0);
    end

    // All three held valid across release: arbitration order.
    rel_pending = 1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NREQ; i++) post(i, 5'(4 + i), $urandom);
      cycle();
      if (k == 0) chk("first_ready", obs_ready, 3'b001);
      chk($sformatf("grant_seq%0d", k), last_g, exp_seq[k]);
    end
    n = 0;
    while ((p_valid[0] || p_valid[1] || p_valid[2]) && n < 8) begin
      cycle();
      n++;
    end

    // Requester 1 writes a busy register.
    iv = 1; ird = 5'd5;
    cycle();
    iv = 0; ird = '0;
    post(1, 5'd5, 32'hDEADBEEF);
    cycle();
    chk("r1_ready", obs_ready, 3'b010);
    cycle();
    chk("r1_we", obs_we, 1'b1);
    chk("r1_addr", obs_waddr, 5'd5);
    chk("r1_data", obs_wdata, 32'hDEADBEEF);
    chk("r1_busy5", obs_busy[5], 1'b0);

    // RAW on x7 stalls until the cycle after the write is accepted.
    iv = 1; ird = 5'd7; irs1 = '0; irs2 = '0;
    cycle();
    ird = '0; irs1 = 5'd7;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("raw_stall", obs_stall, 1'b1);
    end
    post(2, 5'd7, $urandom);
    cycle();
    chk("raw_stall_xfer", obs_stall, 1'b1);
    cycle();
    chk("raw_release", obs_stall, 1'b0);
    iv = 0; irs1 = '0;

    // Set and clear of x9 on the same edge: set wins.
    iv = 1; ird = 5'd9;
    post(0, 5'd9, $urandom);
    cycle();
    iv = 0; ird = '0;
    cycle();
    chk("set_wins", obs_busy[9], 1'b1);

    // Write to x0 is accepted but suppressed.
    b0 = busy;
    post(0, 5'd0, 32'h1234);
    cycle();
    chk("x0_ready", obs_ready, 3'b001);
    cycle();
    chk("x0_we", obs_we, 1'b0);
    chk("x0_busy", obs_busy, b0);

    // Random traffic with a reset partway through.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b0;
        #1;
        chk("midrst_ready", req_ready, 3'b000);
        chk("midrst_we", wb_we, 1'b0);
        chk("midrst_busy", busy, 32'd0);
        @(negedge clk);
        exp_q.delete();
        model_reset();
        rel_pending = 1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1) post(i, 5'($urandom_range(0, 15)), $urandom);
      end
      iv   = ($urandom_range(0, 1) == 1);
      ird  = 5'($urandom_range(0, 15));
      irs1 = 5'($urandom_range(0, 15));
      irs2 = 5'($urandom_range(0, 15));
      cycle();
    end

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of writeback requesters (range 2..8).
REQ-002 The block SHALL have parameter XLEN, default 32, giving the data width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester writeback request.
REQ-006 req_ready  output  NUM_REQ  per-requester grant; a transfer occurs when valid and ready are both high.
REQ-007 req_addr  input  5*NUM_REQ  destination register per requester; requester i occupies bits [5i+4:5i].
REQ-008 req_data  input  XLEN*NUM_REQ  write data per requester; requester i occupies bits [XLEN*i+XLEN-1:XLEN*i].
REQ-009 issue_valid  input  1  decode stage presents an instruction.
REQ-010 issue_rd / issue_rs1 / issue_rs2  input  5 each  destination and source registers of the issuing instruction.
REQ-011 stall  output  1  issue blocked by a hazard.
REQ-012 wb_we / wb_addr / wb_data  output  1 / 5 / XLEN  registered register-file write port.
REQ-013 busy  output  32  scoreboard of registers with a write pending.

Function
REQ-014 The arbiter SHALL assert at most one req_ready bit per cycle, and only to a requester whose req_valid is high; req_ready SHALL be combinational from req_valid and the arbitration state.
REQ-015 Requesters SHALL hold req_valid, req_addr and req_data stable until their transfer completes; the block SHALL not need to tolerate a request being withdrawn.
REQ-016 A transfer at edge N SHALL drive wb_we=1, wb_addr and wb_data during the cycle following edge N, giving a latency of one cycle.
REQ-017 wb_we SHALL be 0 in any cycle that follows an edge with no transfer.
REQ-018 A transfer with req_addr=0 SHALL be accepted (ready high), SHALL drive wb_we=0, and SHALL leave busy unchanged.
REQ-019 busy[r] SHALL be set at an edge where issue_valid=1, stall=0 and issue_rd=r, for r!=0.
REQ-020 busy[r] SHALL be cleared at an edge where a transfer with addr r completes.
REQ-021 If a set and a clear of the same busy bit occur at the same edge, the set SHALL win.
REQ-022 busy[0] SHALL be constantly 0.
REQ-023 stall SHALL be combinational and equal to issue_valid AND (busy[issue_rs1] OR busy[issue_rs2] OR busy[issue_rd]), which covers RAW and WAW hazards; register 0 never contributes.
REQ-024 stall SHALL NOT be released early by a same-cycle transfer; the release is visible on the cycle after the clearing edge.

Reset
REQ-025 While rst is high, the block SHALL force wb_we=0, wb_addr=0, wb_data=0, busy=0, req_ready=0 and the round-robin pointer to NUM_REQ-1, so that requester 0 has first priority.
REQ-026 Assertion of rst mid-operation SHALL drop in-flight requests and pending writes; there SHALL be no partial write.

Configuration
REQ-027 With ARB_RR_EN defined, the grant SHALL go round-robin: the search starts at index (last_grant+1) mod NUM_REQ, and the pointer updates only on a transfer.
REQ-028 Without ARB_RR_EN, the grant SHALL use fixed priority with index 0 highest, and no pointer register SHALL exist.

Structure
REQ-029 The shared package regfile_pkg SHALL hold XLEN, REG_ADDR_W=5 and NUM_REGS=32, for use by both the register file and this block.
REQ-030 The grant logic SHALL be a separate sub-module, wb_rr_arbiter (inputs: req vector, transfer flag; output: one-hot grant), which contains the ARB_RR_EN option.
REQ-031 The scoreboard and output register SHALL stay in the top module.

Verification
REQ-032 Reset with all valids high -> req_ready=0, wb_we=0 and busy=0 throughout reset; on the first cycle after release, req_ready=3'b001.
REQ-033 Requester 1 alone, addr=5, data=0xDEADBEEF -> ready[1]=1 in that cycle; the next cycle shows wb_we=1, wb_addr=5 and wb_data=0xDEADBEEF; busy[5] clears.
REQ-034 All three requesters valid and held, with ARB_RR_EN -> grants in order 0,1,2,0; without ARB_RR_EN -> requester 0 wins until it drops valid.
REQ-035 Issue rd=7, then issue rs1=7 on the next cycle -> stall=1 until the cycle after the transfer to addr 7 is accepted, then stall=0.
REQ-036 Issue rd=9 at the same edge as a transfer to addr 9 completes -> busy[9] remains 1.
REQ-037 Transfer to addr=0 with data=0x1234 -> ready=1, the following cycle shows wb_we=0, and busy is unchanged.
